// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset vector, NOP encoding
// and the fetch FSM state type.
package ifu_fetch_pkg;

  localparam int          INST_ADDR_BUS  = 32;
  localparam int          INST_DATA_BUS  = 32;
  localparam logic [31:0] CPU_RESET_ADDR = 32'h8000_0000;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and
// hands {pc, inst} downstream over valid/ready; redirects flush stale reads.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_BUS,
  parameter int                DATA_W     = INST_DATA_BUS,
  parameter logic [ADDR_W-1:0] RESET_ADDR = CPU_RESET_ADDR[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              o_fault
);

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(3'd4);
  localparam logic [DATA_W-1:0] NOP_INST = DATA_W'(INST_NOP);

  ifu_state_t        state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic              drop_r, drop_s;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_s;
  logic [DATA_W-1:0] fetch_inst_r, fetch_inst_s;
  logic              fault_r, fault_s;
  logic              req_valid_r, out_valid_r;
  logic [ADDR_W-1:0] redirect_aligned_s;
  logic              req_accept_s;

  assign redirect_aligned_s = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign req_accept_s       = (state_r == REQ) && imem_req_ready;

  // Next-state, next-PC and capture logic; redirect outranks everything else.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    drop_s       = drop_r;
    fetch_pc_s   = fetch_pc_r;
    fetch_inst_s = fetch_inst_r;
    fault_s      = fault_r;
    case (state_r)
      IDLE: begin
        state_s = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_s = redirect_aligned_s;
          if (req_accept_s) begin
            state_s = WAIT;
            drop_s  = 1'b1;
          end else begin
            state_s = REQ;
          end
        end else if (req_accept_s) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_s = redirect_aligned_s;
          // A response landing with the redirect is stale; otherwise mark the next one.
          if (imem_resp_valid) begin
            drop_s  = 1'b0;
            state_s = REQ;
          end else begin
            drop_s  = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_r) begin
            drop_s  = 1'b0;
            state_s = REQ;
          end else begin
            fetch_pc_s   = pc_r;
            fetch_inst_s = imem_resp_err ? NOP_INST : imem_resp_data;
            fault_s      = imem_resp_err;
            state_s      = HOLD;
          end
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_s    = redirect_aligned_s;
          state_s = REQ;
        end else if (o_ready) begin
          pc_s    = pc_r + PC_STEP;
          state_s = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, PC and presented-instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_ADDR;
      drop_r       <= 1'b0;
      fetch_pc_r   <= RESET_ADDR;
      fetch_inst_r <= NOP_INST;
      fault_r      <= 1'b0;
      req_valid_r  <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      drop_r       <= drop_s;
      fetch_pc_r   <= fetch_pc_s;
      fetch_inst_r <= fetch_inst_s;
      fault_r      <= fault_s;
      req_valid_r  <= (state_s == REQ);
      out_valid_r  <= (state_s == HOLD);
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign o_valid        = out_valid_r;
  assign fetch_pc       = fetch_pc_r;
  assign fetch_inst     = fetch_inst_r;
  assign o_fault        = fault_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a one-outstanding, one-cycle memory model.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        o_fault;

  logic        pend_r;
  logic [31:0] pend_addr_r;
  logic        mem_stall;
  logic        stray;
  logic [31:0] err_addr;
  int          cyc_r;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .o_valid        (o_valid),
    .o_ready        (o_ready),
    .fetch_pc       (fetch_pc),
    .fetch_inst     (fetch_inst),
    .o_fault        (o_fault)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: latch an accepted request, answer it in the following cycle unless stalled.
  always @(posedge clk) begin
    cyc_r <= cyc_r + 1;
    if (!rst_n) begin
      pend_r <= 1'b0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend_r      <= 1'b1;
      pend_addr_r <= imem_req_addr;
    end else if (imem_resp_valid) begin
      pend_r <= 1'b0;
    end
  end

  assign imem_resp_valid = (pend_r && !mem_stall) || stray;
  assign imem_resp_data  = mem_data(pend_addr_r);
  assign imem_resp_err   = pend_r && (pend_addr_r == err_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!o_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!o_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic flt);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, "_pc"}, fetch_pc, pc);
    chk({tag, "_inst"}, fetch_inst, inst);
    chk({tag, "_fault"}, {31'd0, o_fault}, {31'd0, flt});
  endtask

  initial begin
    int t_prev;
    int t_now;
    logic [31:0] exp_pc;
    cyc_r          = 0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    o_ready        = 1'b1;
    mem_stall      = 1'b0;
    stray          = 1'b0;
    err_addr       = 32'h8000_0010;
    t_prev         = 0;
    repeat (3) @(negedge clk);

    // 1: reset state, then 1 instruction per 3 cycles
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'h8000_0000);
    chk("rst_fetch_inst", fetch_inst, 32'h0000_0013);
    chk("rst_fault", {31'd0, o_fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h8000_0000 + 32'(i * 4);
      wait_valid(10);
      t_now = cyc_r;
      chk_out("seq", exp_pc, mem_data(exp_pc), 1'b0);
      if (i > 0) chk("seq_cadence", 32'(t_now - t_prev), 32'd3);
      t_prev = t_now;
      @(negedge clk);
    end

    // 2: downstream stall keeps HOLD stable and no request goes out
    o_ready = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", fetch_pc, 32'h8000_000C);
      chk("stall_inst", fetch_inst, mem_data(32'h8000_000C));
      chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    o_ready = 1'b1;
    @(negedge clk);

    // 5: access fault presents NOP with o_fault
    wait_valid(10);
    chk_out("fault", 32'h8000_0010, 32'h0000_0013, 1'b1);
    @(negedge clk);

    // 3: redirect while WAIT drops the pending response
    chk("pre_redir_req_addr", imem_req_addr, 32'h8000_0014);
    mem_stall = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_stall      = 1'b0;
    @(negedge clk);
    chk("wait_redir_no_valid", {31'd0, o_valid}, 32'd0);
    chk("wait_redir_req_addr", imem_req_addr, 32'h8000_0100);

    // 4: redirect in HOLD with o_ready=1 aligns target and skips pc+4
    wait_valid(10);
    chk_out("wait_redir", 32'h8000_0100, mem_data(32'h8000_0100), 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("hold_redir_req_addr", imem_req_addr, 32'h8000_0200);
    wait_valid(10);
    chk_out("hold_redir", 32'h8000_0200, mem_data(32'h8000_0200), 1'b0);
    @(negedge clk);

    // Redirect coinciding with request accept: in-flight response discarded
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_valid(10);
    chk_out("req_acc_redir", 32'h8000_0300, mem_data(32'h8000_0300), 1'b0);
    @(negedge clk);

    // Redirect in REQ without accept: address switches before issue
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("req_redir_addr", imem_req_addr, 32'h8000_0400);
    imem_req_ready = 1'b1;
    wait_valid(10);
    chk_out("req_redir", 32'h8000_0400, mem_data(32'h8000_0400), 1'b0);

    // PC wrap past the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_valid(10);
    chk_out("wrap_top", 32'hFFFF_FFFC, mem_data(32'hFFFF_FFFC), 1'b0);
    @(negedge clk);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);

    // 6: reset during WAIT, stray response after release is ignored
    mem_stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("midrst_pc", imem_req_addr, 32'h8000_0000);
    rst_n     = 1'b1;
    mem_stall = 1'b0;
    stray     = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_o_valid", {31'd0, o_valid}, 32'd0);
    chk("stray_req_addr", imem_req_addr, 32'h8000_0000);
    wait_valid(10);
    chk_out("after_rst", 32'h8000_0000, mem_data(32'h8000_0000), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
